// File: rtl/hapara_icap_stream_feeder_pkg.sv
// Shared state encoding, ICAP word geometry and the per-byte bit reversal
// used by the ICAP stream feeder.
package hapara_icap_stream_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_e;

    localparam int ICAP_WIDTH      = 32;
    localparam int BYTE_ADDR_SHIFT = 2;

    // ICAP X32 ordering: reverse the bit order inside every byte, byte order kept.
    function automatic logic [ICAP_WIDTH-1:0] bitswap_bytes(input logic [ICAP_WIDTH-1:0] w);
        logic [ICAP_WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < ICAP_WIDTH / 8; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[8*b+i] = w[8*b+7-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hapara_icap_fifo.sv
// Synchronous fall-through FIFO buffering bitstream words between the
// stream input and the ICAP write side; clear_i empties it in one cycle.
module hapara_icap_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage is not reset: only words below count_q are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/hapara_icap_stream_feeder.sv
// Replays a buffered 32-bit bitstream stream as paced ICAP burst-port word
// writes, with length/tlast checking, abort and done/error reporting.
module hapara_icap_stream_feeder
    import hapara_icap_stream_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_WIDTH  = 24,
    parameter bit BITSWAP    = 1'b1,
    parameter int WR_GAP     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    len_words,
    input  logic                    abort,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    output logic                    s_tready,
    output logic                    icap_en,
    output logic [DATA_WIDTH/8-1:0] icap_we,
    output logic [DATA_WIDTH-1:0]   icap_addr,
    output logic [DATA_WIDTH-1:0]   icap_din,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [LEN_WIDTH-1:0]    words_sent
);
    localparam int               GAP_W    = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(WR_GAP);

    feeder_state_e           state_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    rx_count_q;
    logic [LEN_WIDTH-1:0]    words_sent_q;
    logic [GAP_W-1:0]        gap_q;
    logic                    rx_stop_q;
    logic                    err_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    icap_en_q;
    logic [DATA_WIDTH/8-1:0] icap_we_q;
    logic [DATA_WIDTH-1:0]   icap_addr_q;
    logic [DATA_WIDTH-1:0]   icap_din_q;

    logic                  running;
    logic                  push;
    logic                  pop;
    logic                  fifo_clear;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  rx_last;
    logic                  all_written;

    // Handshake: a word moves when s_tvalid & s_tready at a rising edge. Ready is
    // also withheld during an abort cycle so no accepted word is silently dropped.
    assign running     = (state_q == ST_RUN);
    assign s_tready    = running & ~abort & ~fifo_full & (rx_count_q < len_q) & ~rx_stop_q;
    assign push        = s_tvalid & s_tready;
    assign pop         = running & ~abort & ~fifo_empty & (gap_q == '0);
    assign fifo_clear  = ~running | abort;
    assign rx_last     = (rx_count_q == len_q - 1'b1);
    assign all_written = (words_sent_q == rx_count_q) & ((rx_count_q == len_q) | rx_stop_q);

    hapara_icap_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (fifo_clear),
        .push_i  (push),
        .data_i  (s_tdata),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            rx_count_q   <= '0;
            words_sent_q <= '0;
            gap_q        <= '0;
            rx_stop_q    <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            icap_en_q    <= 1'b0;
            icap_we_q    <= '0;
            icap_addr_q  <= '0;
            icap_din_q   <= '0;
        end else begin
            icap_en_q <= 1'b0;
            icap_we_q <= '0;
            done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        len_q        <= len_words;
                        rx_count_q   <= '0;
                        words_sent_q <= '0;
                        rx_stop_q    <= 1'b0;
                        gap_q        <= '0;
                        if (len_words != '0) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                            err_q   <= 1'b0;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q <= ST_FLUSH;
                        err_q   <= 1'b1;
                    end else begin
                        if (push) begin
                            rx_count_q <= rx_count_q + 1'b1;
                            if (s_tlast && !rx_last) begin
                                err_q     <= 1'b1;
                                rx_stop_q <= 1'b1;
                            end
                            if (rx_last && !s_tlast) err_q <= 1'b1;
                        end
                        if (pop) begin
                            icap_en_q    <= 1'b1;
                            icap_we_q    <= '1;
                            icap_addr_q  <= DATA_WIDTH'(words_sent_q) << BYTE_ADDR_SHIFT;
                            icap_din_q   <= BITSWAP ? bitswap_bytes(fifo_dout) : fifo_dout;
                            words_sent_q <= words_sent_q + 1'b1;
                            gap_q        <= GAP_LOAD;
                        end else if (gap_q != '0) begin
                            gap_q <= gap_q - 1'b1;
                        end
                        // Nothing can be pushed or popped once this holds.
                        if (all_written) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign icap_en    = icap_en_q;
    assign icap_we    = icap_we_q;
    assign icap_addr  = icap_addr_q;
    assign icap_din   = icap_din_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_hapara_icap_stream_feeder.sv
// Bench for the ICAP stream feeder: a back-to-back instance and a paced,
// shallow-FIFO instance, selected per transfer, checked against a word-queue model.
module tb_hapara_icap_stream_feeder;
    localparam int LW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, abort, s_tvalid, s_tlast, sel;
    logic [LW-1:0] len_words;
    logic [31:0]   s_tdata;

    logic          f_tready, f_en, f_busy, f_done, f_err;
    logic [3:0]    f_we;
    logic [31:0]   f_addr, f_din;
    logic [LW-1:0] f_ws;
    logic          g_tready, g_en, g_busy, g_done, g_err;
    logic [3:0]    g_we;
    logic [31:0]   g_addr, g_din;
    logic [LW-1:0] g_ws;

    hapara_icap_stream_feeder #(.FIFO_DEPTH(16), .WR_GAP(0)) u_fast (
        .clk(clk), .rst(rst), .start(start & ~sel), .len_words(len_words), .abort(abort & ~sel),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid & ~sel), .s_tlast(s_tlast), .s_tready(f_tready),
        .icap_en(f_en), .icap_we(f_we), .icap_addr(f_addr), .icap_din(f_din),
        .busy(f_busy), .done(f_done), .err(f_err), .words_sent(f_ws)
    );

    hapara_icap_stream_feeder #(.FIFO_DEPTH(4), .WR_GAP(2)) u_slow (
        .clk(clk), .rst(rst), .start(start & sel), .len_words(len_words), .abort(abort & sel),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid & sel), .s_tlast(s_tlast), .s_tready(g_tready),
        .icap_en(g_en), .icap_we(g_we), .icap_addr(g_addr), .icap_din(g_din),
        .busy(g_busy), .done(g_done), .err(g_err), .words_sent(g_ws)
    );

    logic          m_tready, m_en, m_busy, m_done, m_err;
    logic [3:0]    m_we;
    logic [31:0]   m_addr, m_din;
    logic [LW-1:0] m_ws;
    assign m_tready = sel ? g_tready : f_tready;
    assign m_en     = sel ? g_en     : f_en;
    assign m_we     = sel ? g_we     : f_we;
    assign m_addr   = sel ? g_addr   : f_addr;
    assign m_din    = sel ? g_din    : f_din;
    assign m_busy   = sel ? g_busy   : f_busy;
    assign m_done   = sel ? g_done   : f_done;
    assign m_err    = sel ? g_err    : f_err;
    assign m_ws     = sel ? g_ws     : f_ws;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference byte-wise bit reversal via the streaming operator.
    function automatic logic [31:0] ref_swap(input logic [31:0] w);
        logic [31:0] r;
        logic [7:0]  b;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            b = w[8*k +: 8];
            r[8*k +: 8] = {<<{b}};
        end
        return r;
    endfunction

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_tready"}, m_tready, 0);
        check_eq({pfx, "_en"},     m_en,     0);
        check_eq({pfx, "_we"},     m_we,     0);
        check_eq({pfx, "_addr"},   m_addr,   0);
        check_eq({pfx, "_din"},    m_din,    0);
        check_eq({pfx, "_busy"},   m_busy,   0);
        check_eq({pfx, "_done"},   m_done,   0);
        check_eq({pfx, "_err"},    m_err,    0);
        check_eq({pfx, "_ws"},     m_ws,     0);
    endtask

    // Runs one transfer; entered and left at posedge+1.
    task automatic do_xfer(input bit use_slow, input int len, input int tlast_idx,
                           input int valid_pct, input int abort_after, input int rst_after,
                           input int budget, output int n_wr, output int lat, output int span,
                           output int full_cnt, output logic [31:0] first_din);
        logic [31:0] words[$];
        logic [31:0] exp_q[$];
        logic [31:0] e;
        int acc, wr, gap, depth, abort_cyc, first_hs, first_en, last_en, rst_phase, fcnt;
        bit stop, exp_err, got_done, aborted, fin;
        acc = 0; wr = 0; abort_cyc = -1; first_hs = -1; first_en = -1; last_en = -1;
        rst_phase = 0; fcnt = 0; stop = 0; got_done = 0; aborted = 0; fin = 0;
        first_din = '0;
        gap     = use_slow ? 2 : 0;
        depth   = use_slow ? 4 : 16;
        exp_err = (len == 0);
        for (int i = 0; i < len; i++) words.push_back((i == 0) ? 32'h01234567 : $urandom());
        sel       = use_slow;
        start     = 1'b1;
        len_words = LW'(len);
        for (int c = 0; c < budget && !fin; c++) begin
            s_tvalid = !stop && (acc < len) && ($urandom_range(99) < valid_pct);
            s_tdata  = (acc < len) ? words[acc] : 32'h0;
            s_tlast  = (acc == tlast_idx);
            abort    = (abort_after >= 0) && !aborted && (wr >= abort_after);
            if (rst_phase == 0 && rst_after >= 0 && wr >= rst_after) begin
                rst = 1'b0; rst_phase = 1;
            end else if (rst_phase == 1) begin
                rst = 1'b1; rst_phase = 2;
            end
            @(negedge clk); cyc++;
            if (rst_phase == 2) begin
                check_all_zero("mid_rst");
                fin = 1;
            end else begin
                if (m_en) begin
                    if (aborted) check_eq("en_after_abort", cyc > abort_cyc + 1, 0);
                    if (exp_q.size() == 0) begin
                        check_eq("en_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("din", m_din, e);
                    end
                    check_eq("addr", m_addr, wr * 4);
                    check_eq("we", m_we, 4'hf);
                    if (last_en >= 0) check_eq("wr_spacing", (cyc - last_en) >= gap + 1, 1);
                    if (first_en < 0) begin first_en = cyc; first_din = m_din; end
                    last_en = cyc;
                    wr++;
                end
                if (!aborted && (acc - wr) == depth) begin
                    check_eq("full_blocks", m_tready, 0);
                    fcnt++;
                end
                if (stop || acc >= len) check_eq("tready_closed", m_tready, 0);
                if (s_tvalid && m_tready) begin
                    if (first_hs < 0) first_hs = cyc;
                    exp_q.push_back(ref_swap(words[acc]));
                    if (s_tlast && acc != len - 1) begin exp_err = 1; stop = 1; end
                    if (acc == len - 1 && !s_tlast) exp_err = 1;
                    acc++;
                end
                if (abort) begin aborted = 1; abort_cyc = cyc; exp_err = 1; end
                if (m_done) begin
                    got_done = 1; fin = 1;
                    check_eq("busy_at_done", m_busy, 0);
                    if (aborted) check_eq("abort_done_lat", cyc - abort_cyc, 2);
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        n_wr = wr; lat = first_en - first_hs; span = last_en - first_en; full_cnt = fcnt;
        if (rst_after < 0) begin
            check_eq("done_seen", got_done, 1);
            check_eq("err_final", m_err, exp_err);
            check_eq("words_sent", m_ws, wr);
            if (!aborted) check_eq("queue_drained", exp_q.size(), 0);
            @(negedge clk); cyc++;
            check_eq("done_one_cycle", m_done, 0);
            check_eq("busy_after_done", m_busy, 0);
            check_eq("err_holds", m_err, exp_err);
            check_eq("ws_holds", m_ws, wr);
            @(posedge clk); #1;
        end else begin
            rst = 1'b1;
            repeat (4) begin
                @(negedge clk); cyc++;
                check_eq("no_done_after_rst", m_done, 0);
                check_eq("no_en_after_rst", m_en, 0);
                @(posedge clk); #1;
            end
        end
    endtask

    int          n, lat, span, fc;
    logic [31:0] fd;

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
        s_tdata = '0; len_words = '0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero("rst_fast");
        sel = 1'b1; #1;
        check_all_zero("rst_slow");
        sel = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // Nominal burst: 4 words back-to-back, tlast on the last one.
        do_xfer(0, 4, 3, 100, -1, -1, 200, n, lat, span, fc, fd);
        check_eq("t1_writes", n, 4);
        check_eq("t1_latency", lat, 2);
        check_eq("t1_back_to_back", span, 3);
        check_eq("t1_din_lo", fd & 32'hff, 32'he6);
        check_eq("t1_din", fd, 32'h80c4a2e6);

        // Paced writes with random input gaps.
        do_xfer(1, 8, 7, 50, -1, -1, 600, n, lat, span, fc, fd);
        check_eq("t2_writes", n, 8);

        // Early tlast.
        do_xfer(0, 6, 2, 100, -1, -1, 200, n, lat, span, fc, fd);
        check_eq("t3_writes", n, 3);

        // Missing tlast on the final word: all words still written.
        do_xfer(0, 3, -1, 100, -1, -1, 200, n, lat, span, fc, fd);
        check_eq("t3b_writes", n, 3);

        // Abort after 5 writes on the paced instance; its FIFO fills first.
        do_xfer(1, 16, 15, 100, 5, -1, 600, n, lat, span, fc, fd);
        check_eq("t4_writes", n, 5);
        check_eq("t4_fifo_full_seen", fc > 0, 1);

        // Zero length, then a normal transfer clears err.
        do_xfer(0, 0, -1, 100, -1, -1, 50, n, lat, span, fc, fd);
        check_eq("t5_writes", n, 0);
        do_xfer(0, 2, 1, 100, -1, -1, 200, n, lat, span, fc, fd);
        check_eq("t5b_writes", n, 2);

        // Reset mid-transfer, then a one-word transfer from address 0.
        do_xfer(0, 10, 9, 100, -1, 3, 400, n, lat, span, fc, fd);
        do_xfer(0, 1, 0, 100, -1, -1, 200, n, lat, span, fc, fd);
        check_eq("t6_writes", n, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
